rate_divider: RTL



---
 rtl/rate_pkg.sv | 29 ++
 rtl/rate_load_lut.sv | 16 +
 rtl/rate_divider.sv | 72 +++++++
 3 files changed

// File: rtl/rate_pkg.sv
// Shared definitions for the rate divider: speed encodings and the
// reload-value function that turns a speed select into a down-counter load.
package rate_pkg;

   typedef enum logic [1:0] {
      SPEED_FULL    = 2'b00,
      SPEED_1HZ     = 2'b01,
      SPEED_HALF    = 2'b10,
      SPEED_QUARTER = 2'b11
   } speed_e;

   // Load L(speed) = period - 1, reduced to the low `width` bits of the counter.
   function automatic logic [63:0] load_value(input speed_e speed,
                                              input logic [63:0] clock_hz,
                                              input int width);
      logic [63:0] raw;
      logic [63:0] mask;
      case (speed)
         SPEED_FULL:    raw = 64'd0;
         SPEED_1HZ:     raw = clock_hz - 64'd1;
         SPEED_HALF:    raw = (clock_hz << 1) - 64'd1;
         SPEED_QUARTER: raw = (clock_hz << 2) - 64'd1;
         default:       raw = 64'd0;
      endcase
      mask = (64'd1 << width) - 64'd1;
      return raw & mask;
   endfunction

endpackage

// File: rtl/rate_load_lut.sv
// Combinational speed-to-load lookup used for every down-counter reload.
module rate_load_lut
   import rate_pkg::*;
#(
   parameter int CLOCK_HZ = 50000000,
   parameter int WIDTH    = 28
) (
   input  logic [1:0]       speed,
   output logic [WIDTH-1:0] load
);

   always_comb begin
      load = WIDTH'(load_value(speed_e'(speed), 64'(CLOCK_HZ), WIDTH));
   end

endmodule

// File: rtl/rate_divider.sv
// Clock-rate divider: down-counter with parallel load that emits a registered
// single-cycle pulse each period; a speed change restarts the period.
module rate_divider
   import rate_pkg::*;
#(
   parameter int CLOCK_HZ = 50000000,
   parameter int WIDTH    = 28
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       speed,
   output logic             pulse,
   output logic [WIDTH-1:0] count
);

   localparam logic [63:0] MAX_LOAD = (64'(CLOCK_HZ) << 2) - 64'd1;

   if (WIDTH < 64 && MAX_LOAD >= (64'd1 << WIDTH)) begin : g_cfg_check
      $error("rate_divider: WIDTH too small to hold 4*CLOCK_HZ-1");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]       speed_q, speed_d;
   logic             pulse_q, pulse_d;
   logic [WIDTH-1:0] load_raw;
   logic [WIDTH-1:0] load_wrap;

   // Raw speed feeds reset and speed-change reloads; speed_q feeds the wrap reload.
   rate_load_lut #(.CLOCK_HZ(CLOCK_HZ), .WIDTH(WIDTH)) u_lut_raw (
      .speed (speed),
      .load  (load_raw)
   );

   rate_load_lut #(.CLOCK_HZ(CLOCK_HZ), .WIDTH(WIDTH)) u_lut_wrap (
      .speed (speed_q),
      .load  (load_wrap)
   );

   always_comb begin
      cnt_d   = cnt_q;
      speed_d = speed_q;
      pulse_d = 1'b0;
      if (speed != speed_q) begin
         speed_d = speed;
         cnt_d   = load_raw;
      end else if (!enable) begin
         cnt_d = cnt_q;
      end else if (cnt_q == {WIDTH{1'b0}}) begin
         pulse_d = 1'b1;
         cnt_d   = load_wrap;
      end else begin
         cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= load_raw;
         speed_q <= speed;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;
   assign count = cnt_q;

endmodule
